// File: rtl/mem_stage_if.sv
// EX->MEM, data-RAM response, MEM->WB and ID feedback signals of the memory stage.
// The stage itself uses the slave view; the surrounding pipeline/bench drives the master view.
interface mem_stage_if;
  logic        mem_pipe_ready;
  logic        mem_pipe_flush;
  logic        mem_pipe_valid;
  logic [31:0] mem_pipe_pc;
  logic [31:0] mem_pipe_instruction;
  logic [2:0]  mem_pipe_mem_opcode;
  logic        mem_pipe_mem_read;
  logic [1:0]  mem_pipe_mem_byte_addr;
  logic        mem_pipe_unsign;
  logic        mem_pipe_rd_write;
  logic [4:0]  mem_pipe_rd_addr;
  logic [31:0] mem_pipe_alu_result;
  logic        dram_data_ok;
  logic [31:0] dram_rdata;
  logic        wb_pipe_ready;
  logic        wb_pipe_flush;
  logic        wb_pipe_valid;
  logic [31:0] wb_pipe_pc;
  logic [31:0] wb_pipe_instruction;
  logic        wb_pipe_rd_write;
  logic [4:0]  wb_pipe_rd_addr;
  logic [31:0] wb_pipe_rd_wdata;
  logic        mem_rd_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_wdata;
  logic        mem_load_pending;

  modport slave (
    output mem_pipe_ready, mem_pipe_flush,
    input  mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction, mem_pipe_mem_opcode,
           mem_pipe_mem_read, mem_pipe_mem_byte_addr, mem_pipe_unsign,
           mem_pipe_rd_write, mem_pipe_rd_addr, mem_pipe_alu_result,
           dram_data_ok, dram_rdata, wb_pipe_ready, wb_pipe_flush,
    output wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_write,
           wb_pipe_rd_addr, wb_pipe_rd_wdata,
           mem_rd_write, mem_rd_addr, mem_rd_wdata, mem_load_pending
  );

  modport master (
    input  mem_pipe_ready, mem_pipe_flush,
    output mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction, mem_pipe_mem_opcode,
           mem_pipe_mem_read, mem_pipe_mem_byte_addr, mem_pipe_unsign,
           mem_pipe_rd_write, mem_pipe_rd_addr, mem_pipe_alu_result,
           dram_data_ok, dram_rdata, wb_pipe_ready, wb_pipe_flush,
    input  wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_write,
           wb_pipe_rd_addr, wb_pipe_rd_wdata,
           mem_rd_write, mem_rd_addr, mem_rd_wdata, mem_load_pending
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-response stage: aligns/extends load data, selects rd data, registers MEM->WB
// and feeds forwarding / load-use information back to ID.
module mem_stage (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_hold_data;
  logic        r_wb_valid;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_instruction;
  logic        r_wb_rd_write;
  logic [4:0]  r_wb_rd_addr;
  logic [31:0] r_wb_rd_wdata;

  logic        w_mem_valid;
  logic        w_is_load;
  logic        w_mem_done;
  logic        w_load_pending;
  logic        w_capture;
  logic        w_wb_load;
  logic [31:0] w_load_ext;
  logic [31:0] w_load_data;
  logic [31:0] w_rd_wdata;

  // Opcode is one-hot: bit0 BYTE, bit1 HALF, bit2 WORD; alignment is not checked.
  function automatic logic [31:0] extract_load(input logic [31:0] raw, input logic [2:0] op,
                                               input logic [1:0] ba, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = raw[{ba, 3'b000} +: 8];
    h = ba[1] ? raw[31:16] : raw[15:0];
    if (op[0]) begin
      r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
    end else if (op[1]) begin
      r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
    end else begin
      r = raw;
    end
    return r;
  endfunction

  assign w_mem_valid = bus.mem_pipe_valid & ~bus.wb_pipe_flush;
  assign w_is_load   = w_mem_valid & bus.mem_pipe_mem_read;
  assign w_load_ext  = extract_load(bus.dram_rdata, bus.mem_pipe_mem_opcode,
                                    bus.mem_pipe_mem_byte_addr, bus.mem_pipe_unsign);

  always_comb begin
    w_mem_done = 1'b0;
    if (w_is_load) begin
      case (r_state)
        ST_IDLE: w_mem_done = bus.dram_data_ok;
        ST_HOLD: w_mem_done = 1'b1;
        default: w_mem_done = 1'b0;
      endcase
    end else begin
      w_mem_done = w_mem_valid;
    end
  end

  // HOLD already stores the extended value, so it bypasses extraction.
  assign w_load_data    = (r_state == ST_HOLD) ? r_hold_data : w_load_ext;
  assign w_rd_wdata     = bus.mem_pipe_mem_read ? w_load_data : bus.mem_pipe_alu_result;
  assign w_load_pending = w_is_load & ~w_mem_done;
  assign w_capture      = (r_state == ST_IDLE) & w_is_load & bus.dram_data_ok & ~bus.wb_pipe_ready;
  assign w_wb_load      = w_mem_valid & w_mem_done & (r_state != ST_DRAIN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_next = ST_HOLD;
        end else if (bus.mem_pipe_valid & bus.mem_pipe_mem_read & bus.wb_pipe_flush &
                     ~bus.dram_data_ok) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.wb_pipe_ready | bus.wb_pipe_flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (bus.dram_data_ok) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold_data <= w_load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
    end else if (bus.wb_pipe_ready) begin
      r_wb_valid <= w_wb_load;
    end
  end

  // Payload is left unreset; it is only meaningful alongside r_wb_valid.
  always_ff @(posedge clk) begin
    if (bus.wb_pipe_ready & w_wb_load) begin
      r_wb_pc          <= bus.mem_pipe_pc;
      r_wb_instruction <= bus.mem_pipe_instruction;
      r_wb_rd_write    <= bus.mem_pipe_rd_write;
      r_wb_rd_addr     <= bus.mem_pipe_rd_addr;
      r_wb_rd_wdata    <= w_rd_wdata;
    end
  end

  assign bus.mem_pipe_ready      = (r_state != ST_DRAIN) &
                                   (~w_mem_valid | (w_mem_done & bus.wb_pipe_ready));
  assign bus.mem_pipe_flush      = bus.wb_pipe_flush;
  assign bus.wb_pipe_valid       = r_wb_valid;
  assign bus.wb_pipe_pc          = r_wb_pc;
  assign bus.wb_pipe_instruction = r_wb_instruction;
  assign bus.wb_pipe_rd_write    = r_wb_rd_write;
  assign bus.wb_pipe_rd_addr     = r_wb_rd_addr;
  assign bus.wb_pipe_rd_wdata    = r_wb_rd_wdata;
  assign bus.mem_rd_write        = w_mem_valid & bus.mem_pipe_rd_write & ~w_load_pending;
  assign bus.mem_rd_addr         = bus.mem_pipe_rd_addr;
  assign bus.mem_rd_wdata        = w_rd_wdata;
  assign bus.mem_load_pending    = w_load_pending;

endmodule
